// File: rtl/dma_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dma_pkg: shared widths and FSM state encoding for the DMA engine      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package dma_pkg;

  localparam int ADDR_W_DEF     = 13;
  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO, head read through a registered pointer  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/dma_stream_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dma_stream_engine: BRAM -> AXI-Stream reader and stream -> BRAM writer |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dma_stream_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_src_addr,
  input  logic [ADDR_W-1:0] cfg_dst_addr,
  input  logic [ADDR_W-1:0] cfg_len,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic              dma_r_ready,
  output logic [ADDR_W-1:0] dma_r_addr,
  input  logic              dma_r_ack,
  input  logic              dma_in_valid,
  input  logic [DATA_W-1:0] dma_r_data,
  output logic              dma_w_valid,
  output logic [ADDR_W-1:0] dma_w_addr,
  output logic [DATA_W-1:0] dma_w_data,
  input  logic              dma_w_ack,
  output logic              sm_tvalid,
  input  logic              sm_tready,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  input  logic              ss_tvalid,
  output logic              ss_tready,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] rd_issued_q, rd_issued_d;
  logic [ADDR_W-1:0] popped_q, popped_d;
  logic [ADDR_W-1:0] wr_rcvd_q, wr_rcvd_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              wreg_full_q, wreg_full_d;
  logic [DATA_W-1:0] wreg_data_q, wreg_data_d;
  logic              err_short_q, err_short_d;

  logic              in_run;
  logic [CNT_W:0]    in_flight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              rd_ack;
  logic              wr_ack;
  logic              ss_beat;
  logic              rd_done;
  logic              wr_done;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_ret_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (fifo_push),
    .push_data (dma_r_data),
    .pop       (fifo_pop),
    .rd_data   (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Requests are masked by reset so they drop in the cycle reset is seen.
  assign in_run    = (state_q == RUN) && !wb_rst_i;
  // Reads in flight plus buffered words never exceed the FIFO depth.
  assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count};

  assign dma_r_ready = in_run && (rd_issued_q < len_q)
                       && (in_flight < (CNT_W+1)'(FIFO_DEPTH));
  assign dma_r_addr  = rd_addr_q;
  assign rd_ack      = dma_r_ready && dma_r_ack;
  assign fifo_push   = dma_in_valid && (outstanding_q != '0);

  assign sm_tvalid = !fifo_empty && !wb_rst_i;
  assign sm_tdata  = sm_tvalid ? fifo_head : '0;
  assign sm_tlast  = sm_tvalid && (popped_q == len_q - ADDR_W'(1));
  assign fifo_pop  = sm_tvalid && sm_tready;

  // The holding register may refill in the same cycle its write is acked.
  assign ss_tready   = in_run && (!wreg_full_q || dma_w_ack)
                       && (wr_rcvd_q < len_q) && !err_short_q;
  assign ss_beat     = ss_tvalid && ss_tready;
  assign wr_ack      = wreg_full_q && dma_w_ack;
  assign dma_w_valid = wreg_full_q && !wb_rst_i;
  assign dma_w_addr  = wr_addr_q;
  assign dma_w_data  = wreg_data_q;

  assign rd_done   = (popped_q == len_q);
  assign wr_done   = !wreg_full_q && ((wr_rcvd_q == len_q) || err_short_q);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err_short = err_short_q;

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    len_d         = len_q;
    rd_issued_d   = rd_issued_q;
    popped_d      = popped_q;
    wr_rcvd_d     = wr_rcvd_q;
    outstanding_d = outstanding_q + CNT_W'(rd_ack) - CNT_W'(fifo_push);
    wreg_full_d   = wreg_full_q;
    wreg_data_d   = wreg_data_q;
    err_short_d   = err_short_q;

    if (rd_ack) begin
      rd_addr_d   = rd_addr_q + ADDR_W'(1);
      rd_issued_d = rd_issued_q + ADDR_W'(1);
    end
    if (fifo_pop) popped_d = popped_q + ADDR_W'(1);
    if (wr_ack) begin
      wreg_full_d = 1'b0;
      wr_addr_d   = wr_addr_q + ADDR_W'(1);
    end
    if (ss_beat) begin
      wreg_full_d = 1'b1;
      wreg_data_d = ss_tdata;
      wr_rcvd_d   = wr_rcvd_q + ADDR_W'(1);
      if (ss_tlast && (wr_rcvd_q != len_q - ADDR_W'(1))) err_short_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          rd_addr_d     = cfg_src_addr;
          wr_addr_d     = cfg_dst_addr;
          len_d         = cfg_len;
          rd_issued_d   = '0;
          popped_d      = '0;
          wr_rcvd_d     = '0;
          outstanding_d = '0;
          wreg_full_d   = 1'b0;
          err_short_d   = 1'b0;
          state_d       = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN:     if (rd_done && wr_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      len_q         <= '0;
      rd_issued_q   <= '0;
      popped_q      <= '0;
      wr_rcvd_q     <= '0;
      outstanding_q <= '0;
      wreg_full_q   <= 1'b0;
      wreg_data_q   <= '0;
      err_short_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      len_q         <= len_d;
      rd_issued_q   <= rd_issued_d;
      popped_q      <= popped_d;
      wr_rcvd_q     <= wr_rcvd_d;
      outstanding_q <= outstanding_d;
      wreg_full_q   <= wreg_full_d;
      wreg_data_q   <= wreg_data_d;
      err_short_q   <= err_short_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_stream_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dma_stream_engine: arbiter/accelerator models plus scoreboard      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_dma_stream_engine;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cfg_start;
  logic [12:0] cfg_src_addr, cfg_dst_addr, cfg_len;
  logic        busy, done, err_short;
  logic        dma_r_ready;
  logic [12:0] dma_r_addr;
  logic        dma_r_ack    = 1'b0;
  logic        dma_in_valid = 1'b0;
  logic [31:0] dma_r_data   = '0;
  logic        dma_w_valid;
  logic [12:0] dma_w_addr;
  logic [31:0] dma_w_data;
  logic        dma_w_ack    = 1'b0;
  logic        sm_tvalid;
  logic        sm_tready;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        ss_tvalid    = 1'b0;
  logic        ss_tready;
  logic [31:0] ss_tdata     = '0;
  logic        ss_tlast     = 1'b0;

  dma_stream_engine dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .cfg_start    (cfg_start),
    .cfg_src_addr (cfg_src_addr),
    .cfg_dst_addr (cfg_dst_addr),
    .cfg_len      (cfg_len),
    .busy         (busy),
    .done         (done),
    .err_short    (err_short),
    .dma_r_ready  (dma_r_ready),
    .dma_r_addr   (dma_r_addr),
    .dma_r_ack    (dma_r_ack),
    .dma_in_valid (dma_in_valid),
    .dma_r_data   (dma_r_data),
    .dma_w_valid  (dma_w_valid),
    .dma_w_addr   (dma_w_addr),
    .dma_w_data   (dma_w_data),
    .dma_w_ack    (dma_w_ack),
    .sm_tvalid    (sm_tvalid),
    .sm_tready    (sm_tready),
    .sm_tdata     (sm_tdata),
    .sm_tlast     (sm_tlast),
    .ss_tvalid    (ss_tvalid),
    .ss_tready    (ss_tready),
    .ss_tdata     (ss_tdata),
    .ss_tlast     (ss_tlast)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [31:0] memf(input logic [12:0] a);
    return {16'hBEEF, 3'b000, a};
  endfunction

  function automatic logic [31:0] ssword(input logic [7:0] tag, input int i);
    return {8'hA5, tag, 16'(i)};
  endfunction

  int checks = 0;
  int errors = 0;

  logic [12:0] exp_ra[$];
  logic [32:0] exp_sm[$];   // {data, last}
  logic [44:0] exp_w[$];    // {addr, data}

  int done_cnt = 0, sm_pops = 0, r_accepts = 0, req_cycles = 0;
  int done_base = 0, pops_base = 0, acc_base = 0, req_base = 0;
  int acc_n = 0, acc_job = 0;
  logic [7:0] acc_tag = '0;

  int          bfm_acc_i = 0, bfm_seen_job = 0;
  logic [12:0] bfm_ack_addr = '0;
  logic        bfm_ss_beat = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected transfer %0h with empty expectation queue", name, act);
  endtask

  // Arbiter and accelerator: decide 2 units after the falling edge, sample 1 unit later.
  initial begin : bfm
    forever begin
      @(negedge wb_clk_i);
      #2;
      if (bfm_ss_beat) bfm_acc_i++;
      if (acc_job != bfm_seen_job) begin
        bfm_seen_job = acc_job;
        bfm_acc_i    = 0;
      end
      if (wb_rst_i) begin
        dma_r_ack    = 1'b0;
        dma_in_valid = 1'b0;
        dma_w_ack    = 1'b0;
        ss_tvalid    = 1'b0;
        ss_tlast     = 1'b0;
      end else begin
        dma_in_valid = dma_r_ack;
        dma_r_data   = dma_r_ack ? memf(bfm_ack_addr) : '0;
        if (dma_r_ready && !dma_r_ack) begin
          dma_r_ack    = 1'b1;
          bfm_ack_addr = dma_r_addr;
        end else begin
          dma_r_ack = 1'b0;
        end
        dma_w_ack = dma_w_valid && !dma_w_ack;
        ss_tvalid = (bfm_acc_i < acc_n);
        ss_tdata  = ss_tvalid ? ssword(acc_tag, bfm_acc_i) : '0;
        ss_tlast  = ss_tvalid && (bfm_acc_i == acc_n - 1);
      end
      #1;
      bfm_ss_beat = ss_tvalid && ss_tready && !wb_rst_i;
    end
  end

  // Scoreboard monitor: pops an expectation whenever the DUT completes a transfer.
  initial begin : monitor
    forever begin
      @(negedge wb_clk_i);
      #4;
      if (!wb_rst_i) begin
        if (dma_r_ready || dma_w_valid) req_cycles++;
        if (done) done_cnt++;
        if (dma_r_ready && dma_r_ack) begin
          r_accepts++;
          if (exp_ra.size() == 0) unexpected("rd_addr", 128'(dma_r_addr));
          else check("rd_addr", 128'(dma_r_addr), 128'(exp_ra.pop_front()));
        end
        if (sm_tvalid && sm_tready) begin
          sm_pops++;
          if (exp_sm.size() == 0) unexpected("sm_beat", 128'({sm_tdata, sm_tlast}));
          else check("sm_beat", 128'({sm_tdata, sm_tlast}), 128'(exp_sm.pop_front()));
        end else if (sm_tvalid && exp_sm.size() != 0) begin
          check("sm_stall_head", 128'({sm_tdata, sm_tlast}), 128'(exp_sm[0]));
        end
        if (dma_w_valid && dma_w_ack) begin
          if (exp_w.size() == 0) unexpected("wr", 128'({dma_w_addr, dma_w_data}));
          else check("wr", 128'({dma_w_addr, dma_w_data}), 128'(exp_w.pop_front()));
        end
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    check(name, 128'({busy, done, err_short, dma_r_ready, dma_r_addr, dma_w_valid,
                      dma_w_addr, dma_w_data, sm_tvalid, sm_tdata, sm_tlast, ss_tready}), '0);
  endtask

  task automatic start_job(input logic [12:0] src, input logic [12:0] dst,
                           input logic [12:0] len, input int acc_words, input logic [7:0] tag);
    logic [12:0] a;
    int nw;
    @(negedge wb_clk_i);
    for (int i = 0; i < int'(len); i++) begin
      a = src + 13'(i);
      exp_ra.push_back(a);
      exp_sm.push_back({memf(a), (i == int'(len) - 1)});
    end
    nw = (acc_words < int'(len)) ? acc_words : int'(len);
    for (int i = 0; i < nw; i++) begin
      a = dst + 13'(i);
      exp_w.push_back({a, ssword(tag, i)});
    end
    done_base    = done_cnt;
    pops_base    = sm_pops;
    acc_base     = r_accepts;
    req_base     = req_cycles;
    cfg_src_addr = src;
    cfg_dst_addr = dst;
    cfg_len      = len;
    cfg_start    = 1'b1;
    acc_n        = acc_words;
    acc_tag      = tag;
    acc_job++;
    @(negedge wb_clk_i);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge wb_clk_i);
      #4;
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 128'(seen), 128'(1));
  endtask

  task automatic end_job(input string name, input logic exp_err);
    repeat (2) @(negedge wb_clk_i);
    #4;
    check({name, "_done_once"}, 128'(done_cnt - done_base), 128'(1));
    check({name, "_queues_left"}, 128'(exp_ra.size() + exp_sm.size() + exp_w.size()), '0);
    check({name, "_err_busy"}, 128'({err_short, busy}), 128'({exp_err, 1'b0}));
  endtask

  initial begin : stimulus
    wb_rst_i     = 1'b1;
    cfg_start    = 1'b0;
    cfg_src_addr = '0;
    cfg_dst_addr = '0;
    cfg_len      = '0;
    sm_tready    = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #4;
    check_outputs_zero("reset_state");

    // Basic copy, tlast only on word 3
    start_job(13'h0010, 13'h0100, 13'd4, 4, 8'h01);
    wait_done("t1");
    end_job("t1", 1'b0);

    // Address wrap on both sides
    start_job(13'h1FFE, 13'h1FFF, 13'd8, 8, 8'h02);
    wait_done("t2");
    end_job("t2", 1'b0);

    // Back-pressure: credits cap accepted reads; a start while busy is ignored
    sm_tready = 1'b0;
    start_job(13'h0020, 13'h0200, 13'd16, 16, 8'h03);
    repeat (8) @(negedge wb_clk_i);
    cfg_src_addr = 13'h0500;
    cfg_len      = 13'd2;
    cfg_start    = 1'b1;
    @(negedge wb_clk_i);
    cfg_start = 1'b0;
    repeat (11) @(negedge wb_clk_i);
    check("t3_accepts_while_stalled", 128'(r_accepts - acc_base), 128'(4));
    sm_tready = 1'b1;
    wait_done("t3");
    end_job("t3", 1'b0);

    // Short return stream
    start_job(13'h0030, 13'h0400, 13'd6, 3, 8'h04);
    wait_done("t4");
    check("t4_pops_at_done", 128'(sm_pops - pops_base), 128'(6));
    end_job("t4", 1'b1);

    // Zero-length job
    start_job(13'h0050, 13'h0500, 13'd0, 0, 8'h05);
    #4;
    check("t5_done_busy", 128'({done, busy, err_short}), 128'(3'b110));
    @(negedge wb_clk_i);
    #4;
    check("t5_after", 128'({done, busy}), '0);
    check("t5_no_requests", 128'(req_cycles - req_base), '0);
    check("t5_done_once", 128'(done_cnt - done_base), 128'(1));

    // Reset in the middle of a job, then a fresh job
    start_job(13'h0060, 13'h0600, 13'd10, 10, 8'h06);
    for (int n = 0; n < 100 && (sm_pops - pops_base) < 4; n++) begin
      @(negedge wb_clk_i);
      #4;
    end
    check("t6_pops_before_reset", 128'((sm_pops - pops_base) >= 4), 128'(1));
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    acc_n    = 0;
    exp_ra.delete();
    exp_sm.delete();
    exp_w.delete();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #4;
    check_outputs_zero("t6_after_reset");
    start_job(13'h0070, 13'h0700, 13'd2, 2, 8'h07);
    wait_done("t6b");
    end_job("t6b", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
